// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches an instruction, decodes ir[31:27] and steps the
// datapath through T-states, raising register-select, bus-driver and memory strobes.
module control_sequencer #(
   parameter int unsigned REG_SIZE = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [REG_SIZE-1:0] ir,
   input  logic                mem_done,
   input  logic                stop,
   output logic                gra,
   output logic                grb,
   output logic                grc,
   output logic                r_in,
   output logic                r_out,
   output logic                ba_out,
   output logic                c_out,
   output logic                pc_out,
   output logic                pc_inc,
   output logic                mar_in,
   output logic                mdr_in,
   output logic                mdr_out,
   output logic                ir_in,
   output logic                y_in,
   output logic                z_in,
   output logic                zlo_out,
   output logic                read,
   output logic                write,
   output logic [3:0]          alu_op,
   output logic                run
);

   typedef enum logic [3:0] {
      StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
   } state_e;

   localparam logic [3:0] AluAdd = 4'b0000;
   localparam logic [3:0] AluSub = 4'b0001;
   localparam logic [3:0] AluAnd = 4'b0010;
   localparam logic [3:0] AluOr  = 4'b0011;

   state_e state_q, state_d;

   logic [4:0] opcode;
   logic       is_ld, is_ldi, is_st, is_alu, is_imm, is_halt, is_mem, is_nop;
   logic [3:0] alu_sel;

   // Only the opcode field is decoded; the operand fields belong to the datapath.
   logic unused_ir;
   assign unused_ir = ^ir;

   assign opcode = ir[31:27];

   always_comb begin
      is_ld   = (opcode == 5'b00000);
      is_ldi  = (opcode == 5'b00001);
      is_st   = (opcode == 5'b00010);
      is_alu  = (opcode == 5'b00011) || (opcode == 5'b00100) ||
                (opcode == 5'b00101) || (opcode == 5'b00110);
      is_imm  = (opcode == 5'b01100) || (opcode == 5'b01101) || (opcode == 5'b01110);
      is_halt = (opcode == 5'b11011);
      is_mem  = is_ld || is_st;
      // Explicit nop and every unlisted opcode share the same empty execute phase.
      is_nop  = !(is_ld || is_ldi || is_st || is_alu || is_imm || is_halt);
      alu_sel = AluAdd;
      case (opcode)
         5'b00100: alu_sel = AluSub;
         5'b00101: alu_sel = AluAnd;
         5'b00110: alu_sel = AluOr;
         5'b01101: alu_sel = AluAnd;
         5'b01110: alu_sel = AluOr;
         default:  alu_sel = AluAdd;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StRst:  state_d = StT0;
         StT0:   state_d = stop ? StHalt : StT1;
         StT1:   state_d = mem_done ? StT2 : StT1;
         StT2:   state_d = StT3;
         StT3: begin
            if (is_halt)     state_d = StHalt;
            else if (is_nop) state_d = StT0;
            else             state_d = StT4;
         end
         StT4:   state_d = StT5;
         StT5:   state_d = is_mem ? StT6 : StT0;
         StT6: begin
            if (is_st)         state_d = StT7;
            else if (mem_done) state_d = StT7;
            else               state_d = StT6;
         end
         StT7: begin
            if (is_ld)         state_d = StT0;
            else if (mem_done) state_d = StT0;
            else               state_d = StT7;
         end
         StHalt: state_d = StHalt;
         default: state_d = StRst;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= StRst;
      else       state_q <= state_d;
   end

   always_comb begin
      gra = 1'b0;     grb = 1'b0;     grc = 1'b0;
      r_in = 1'b0;    r_out = 1'b0;   ba_out = 1'b0;  c_out = 1'b0;
      pc_out = 1'b0;  pc_inc = 1'b0;  mar_in = 1'b0;
      mdr_in = 1'b0;  mdr_out = 1'b0; ir_in = 1'b0;
      y_in = 1'b0;    z_in = 1'b0;    zlo_out = 1'b0;
      read = 1'b0;    write = 1'b0;   alu_op = AluAdd;
      run = (state_q != StRst) && (state_q != StHalt);
      case (state_q)
         StT0: begin
            // A halt request suppresses the fetch so the PC is left untouched.
            if (!stop) begin
               pc_out = 1'b1;
               mar_in = 1'b1;
               pc_inc = 1'b1;
            end
         end
         StT1: begin
            read   = 1'b1;
            mdr_in = 1'b1;
         end
         StT2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         StT3: begin
            if (is_alu || is_imm) begin
               grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
            end else if (is_ldi || is_mem) begin
               grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
            end
         end
         StT4: begin
            if (is_alu) begin
               grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_sel;
            end else if (is_imm || is_ldi || is_mem) begin
               c_out = 1'b1; z_in = 1'b1; alu_op = alu_sel;
            end
         end
         StT5: begin
            zlo_out = 1'b1;
            if (is_mem) begin
               mar_in = 1'b1;
            end else begin
               gra = 1'b1; r_in = 1'b1;
            end
         end
         StT6: begin
            mdr_in = 1'b1;
            if (is_st) begin
               gra = 1'b1; r_out = 1'b1;
            end else begin
               read = 1'b1;
            end
         end
         StT7: begin
            if (is_st) begin
               write = 1'b1;
            end else begin
               mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: builds the expected per-cycle strobe trace of each instruction from the
// instruction-class tables and replays it cycle by cycle against the sequencer.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ir = '0;
   logic        mem_done = 1'b0;
   logic        stop = 1'b0;
   logic gra, grb, grc, r_in, r_out, ba_out, c_out, pc_out, pc_inc, mar_in;
   logic mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, read, write, run;
   logic [3:0] alu_op;

   control_sequencer #(.REG_SIZE(32)) dut (
      .clk(clk), .reset(reset), .ir(ir), .mem_done(mem_done), .stop(stop),
      .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
      .c_out(c_out), .pc_out(pc_out), .pc_inc(pc_inc), .mar_in(mar_in), .mdr_in(mdr_in),
      .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out),
      .read(read), .write(write), .alu_op(alu_op), .run(run)
   );

   always #5 clk = ~clk;

   localparam logic [22:0] GRA = 23'd1 << 0,  GRB = 23'd1 << 1,  GRC = 23'd1 << 2;
   localparam logic [22:0] RIN = 23'd1 << 3,  ROUT = 23'd1 << 4, BAOUT = 23'd1 << 5;
   localparam logic [22:0] COUT = 23'd1 << 6, PCOUT = 23'd1 << 7, PCINC = 23'd1 << 8;
   localparam logic [22:0] MARIN = 23'd1 << 9, MDRIN = 23'd1 << 10, MDROUT = 23'd1 << 11;
   localparam logic [22:0] IRIN = 23'd1 << 12, YIN = 23'd1 << 13, ZIN = 23'd1 << 14;
   localparam logic [22:0] ZLOOUT = 23'd1 << 15, READ = 23'd1 << 16, WRITE = 23'd1 << 17;
   localparam logic [22:0] RUN = 23'd1 << 22;

   localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
   localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101;
   localparam logic [4:0] OP_OR = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI = 5'b01110, OP_NOP = 5'b11010, OP_HALT = 5'b11011;

   logic [22:0] obs;
   assign obs = {run, alu_op, write, read, zlo_out, z_in, y_in, ir_in, mdr_out, mdr_in,
                 mar_in, pc_inc, pc_out, c_out, ba_out, r_out, r_in, grc, grb, gra};

   typedef struct {
      logic [22:0] exp;
      bit          md;
      bit          stp;
      bit          rst;
      logic [31:0] irv;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Instruction classes as listed in the opcode table.
   typedef enum int {CNop, CHalt, CAlu, CImm, CLdi, CLd, CSt} cls_e;

   function automatic cls_e classify(input logic [4:0] op);
      case (op)
         OP_LD: return CLd;
         OP_LDI: return CLdi;
         OP_ST: return CSt;
         OP_ADD, OP_SUB, OP_AND, OP_OR: return CAlu;
         OP_ADDI, OP_ANDI, OP_ORI: return CImm;
         OP_HALT: return CHalt;
         default: return CNop;
      endcase
   endfunction

   function automatic logic [22:0] alu_bits(input logic [4:0] op);
      logic [3:0] a;
      case (op)
         OP_SUB: a = 4'd1;
         OP_AND, OP_ANDI: a = 4'd2;
         OP_OR, OP_ORI: a = 4'd3;
         default: a = 4'd0;
      endcase
      return {1'b0, a, 18'd0};
   endfunction

   task automatic push(input logic [22:0] e, input bit md, input bit stp, input bit rst,
                       input logic [31:0] irv);
      ent_t x;
      x.exp = e; x.md = md; x.stp = stp; x.rst = rst; x.irv = irv;
      q.push_back(x);
   endtask

   // Non-wait cycles get random mem_done and stop, which the sequencer must ignore.
   task automatic push_any(input logic [22:0] e, input logic [31:0] irv);
      push(e, 1'($urandom), 1'($urandom), 1'b0, irv);
   endtask

   task automatic push_halt_cycles(input int n);
      for (int i = 0; i < n; i++) push_any(23'd0, $urandom);
   endtask

   // Reset seen during the last cycle of whatever precedes it, then one cycle in RST.
   task automatic push_reset(input logic [22:0] cur);
      push(cur, 1'($urandom), 1'($urandom), 1'b1, $urandom);
      push(23'd0, 1'($urandom), 1'($urandom), 1'b0, $urandom);
   endtask

   task automatic gen_instr(input logic [4:0] op, input int d1, input int d2,
                            input bit stp, input bit abort_t6);
      logic [31:0] iv;
      cls_e c;
      iv = {op, 27'($urandom)};
      c = classify(op);
      if (stp) begin
         push(RUN, 1'($urandom), 1'b1, 1'b0, $urandom);
         push_halt_cycles(5);
         return;
      end
      push(RUN | PCOUT | MARIN | PCINC, 1'($urandom), 1'b0, 1'b0, $urandom);
      for (int i = 0; i <= d1; i++)
         push(RUN | READ | MDRIN, (i == d1), 1'($urandom), 1'b0, $urandom);
      push_any(RUN | MDROUT | IRIN, iv);
      case (c)
         CNop: push_any(RUN, iv);
         CHalt: begin
            push_any(RUN, iv);
            push_halt_cycles(20);
         end
         default: begin
            if (c == CAlu || c == CImm) push_any(RUN | GRB | ROUT | YIN, iv);
            else                        push_any(RUN | GRB | BAOUT | YIN, iv);
            if (c == CAlu) push_any(RUN | GRC | ROUT | ZIN | alu_bits(op), iv);
            else           push_any(RUN | COUT | ZIN | alu_bits(op), iv);
            if (c == CLd || c == CSt) push_any(RUN | ZLOOUT | MARIN, iv);
            else                      push_any(RUN | ZLOOUT | GRA | RIN, iv);
            if (c == CLd) begin
               if (abort_t6) begin
                  push(RUN | READ | MDRIN, 1'b0, 1'($urandom), 1'b0, iv);
                  push_reset(RUN | READ | MDRIN);
                  return;
               end
               for (int i = 0; i <= d2; i++)
                  push(RUN | READ | MDRIN, (i == d2), 1'($urandom), 1'b0, iv);
               push_any(RUN | MDROUT | GRA | RIN, iv);
            end else if (c == CSt) begin
               push_any(RUN | GRA | ROUT | MDRIN, iv);
               for (int i = 0; i <= d2; i++)
                  push(RUN | WRITE, (i == d2), 1'($urandom), 1'b0, iv);
            end
         end
      endcase
   endtask

   task automatic run_q(input string name);
      ent_t e;
      int   n = 0;
      logic [5:0] drivers;
      while (q.size() > 0) begin
         e = q.pop_front();
         @(negedge clk);
         reset = e.rst; mem_done = e.md; stop = e.stp; ir = e.irv;
         #1;
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s cycle %0d strobes got %h want %h", name, n, obs, e.exp);
         end
         drivers = {r_out, ba_out, c_out, pc_out, mdr_out, zlo_out};
         checks++;
         if ($countones(drivers) > 1 || $countones({gra, grb, grc}) > 1 || (read && write)) begin
            errors++;
            $display("FAIL %s cycle %0d exclusivity got drv=%b gr=%b rw=%b want one-hot-or-zero",
                     name, n, drivers, {gra, grb, grc}, {read, write});
         end
         n++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (obs !== 23'd0) begin
         errors++;
         $display("FAIL reset_state got %h want %h", obs, 23'd0);
      end
      reset = 1'b0;
   endtask

   task automatic test_alu;
      gen_instr(OP_ADD, 0, 0, 0, 0);
      gen_instr(OP_SUB, 0, 0, 0, 0);
      gen_instr(OP_AND, 1, 0, 0, 0);
      gen_instr(OP_OR, 0, 0, 0, 0);
      run_q("alu");
   endtask

   task automatic test_imm;
      gen_instr(OP_ADDI, 0, 0, 0, 0);
      gen_instr(OP_ANDI, 0, 0, 0, 0);
      gen_instr(OP_ORI, 2, 0, 0, 0);
      gen_instr(OP_LDI, 0, 0, 0, 0);
      run_q("imm");
   endtask

   task automatic test_ld_wait;
      gen_instr(OP_LD, 3, 3, 0, 0);
      gen_instr(OP_LD, 0, 0, 0, 0);
      run_q("ld_wait");
   endtask

   task automatic test_st;
      gen_instr(OP_ST, 0, 0, 0, 0);
      gen_instr(OP_ST, 2, 3, 0, 0);
      run_q("st");
   endtask

   task automatic test_nop_illegal;
      gen_instr(OP_NOP, 0, 0, 0, 0);
      gen_instr(5'b11111, 0, 0, 0, 0);
      gen_instr(5'b10101, 1, 0, 0, 0);
      run_q("nop_illegal");
   endtask

   task automatic test_halt;
      gen_instr(OP_ADD, 0, 0, 0, 0);
      gen_instr(OP_HALT, 0, 0, 0, 0);
      push_reset(23'd0);
      gen_instr(OP_NOP, 0, 0, 1, 0);
      push_reset(23'd0);
      gen_instr(OP_ADDI, 0, 0, 0, 0);
      run_q("halt_stop");
   endtask

   task automatic test_reset_mid;
      gen_instr(OP_LD, 0, 0, 0, 1);
      gen_instr(5'b11111, 0, 0, 0, 0);
      run_q("reset_mid");
   endtask

   task automatic test_back_to_back;
      logic [4:0] ops [12];
      ops = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
              OP_ORI, OP_NOP, 5'b10011};
      for (int i = 0; i < 40; i++)
         gen_instr(ops[$urandom_range(11)], $urandom_range(3), $urandom_range(3), 0, 0);
      run_q("back_to_back");
   endtask

   initial begin
      test_reset();
      test_alu();
      test_imm();
      test_ld_wait();
      test_st();
      test_nop_illegal();
      test_halt();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
